key_debounce: RTL and testbench

- Upstream conditioning stage for the 4-bit key PIO slave.
- Takes raw, bouncing, active-low push-button pins from the board.
- Synchronises each pin to clk and qualifies each level with a per-key stability counter.
- Drives the clean levels into the PIO in_port, so the PIO falling-edge capture fires exactly once per physical press. It also provides one-cycle press/release strobes for local logic.

---
 rtl/key_debounce_pkg.sv | 11 +
 rtl/key_debounce_if.sv | 16 +
 rtl/key_debounce_channel.sv | 92 +++++++++
 rtl/key_debounce.sv | 30 +++
 tb/tb_key_debounce.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants and channel FSM state encoding for the key debouncer.
package key_debounce_pkg;

    localparam int unsigned DEFAULT_NUM_KEYS        = 4;
    localparam int unsigned DEFAULT_CNT_WIDTH       = 20;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

    localparam logic [0:0] ST_STABLE  = 1'b0;
    localparam logic [0:0] ST_QUALIFY = 1'b1;

endpackage

// File: rtl/key_debounce_if.sv
// Key bundle between board pins, debouncer and the PIO in_port.
interface key_debounce_if
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS = DEFAULT_NUM_KEYS
) ();

    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_out;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;

    modport master (output key_in, input key_out, input key_press, input key_release);
    modport slave  (input key_in, output key_out, output key_press, output key_release);

endinterface

// File: rtl/key_debounce_channel.sv
// One key: two-flop synchroniser, stability counter FSM, registered level and strobes.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic key_out,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s1;
    logic                 s2;
    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 out_nxt;
    logic                 press_nxt;
    logic                 release_nxt;

    // Synchroniser; s2 is the only view of the pin used below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_LEVEL;
            s2 <= RESET_LEVEL;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_STABLE;
            cnt         <= '0;
            key_out     <= RESET_LEVEL;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_out     <= out_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    // Any return of s2 to the accepted level restarts qualification.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        out_nxt     = key_out;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            ST_STABLE: begin
                cnt_nxt = '0;
                if (s2 != key_out) begin
                    state_nxt = ST_QUALIFY;
                    cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            ST_QUALIFY: begin
                if (s2 == key_out) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = ST_STABLE;
                    cnt_nxt     = '0;
                    out_nxt     = s2;
                    press_nxt   = ~s2;
                    release_nxt = s2;
                end else begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low push buttons; one independent channel per key.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic           clk,
    input  logic           reset_n,
    key_debounce_if.slave  bus
);

    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_ch
        key_debounce_channel #(
            .CNT_WIDTH       (CNT_WIDTH),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_in      (bus.key_in[i]),
            .key_out     (bus.key_out[i]),
            .key_press   (bus.key_press[i]),
            .key_release (bus.key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench: expected strobes queued at stimulus time, popped by a strobe monitor.
module tb_key_debounce;

    localparam int unsigned NK  = 4;
    localparam int unsigned DC  = 8;
    localparam int unsigned LAT = DC + 2;

    typedef struct {
        int unsigned   at;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] out;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    key_debounce_if #(.NUM_KEYS(NK)) bus ();

    key_debounce #(
        .NUM_KEYS        (NK),
        .CNT_WIDTH       (4),
        .DEBOUNCE_CYCLES (DC),
        .RESET_LEVEL     (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_strobe(input logic [NK-1:0] p, input logic [NK-1:0] r, input logic [NK-1:0] o);
        exp_t e;
        e.at = cyc + LAT; e.press = p; e.rel = r; e.out = o;
        sb.push_back(e);
    endtask

    // Strobe monitor: every strobe cycle must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && ((bus.key_press | bus.key_release) != '0)) begin
            total++;
            if ((bus.key_press & bus.key_release) != '0) begin
                bad++;
                $display("FAIL both_strobes: press %b release %b cycle %0d", bus.key_press, bus.key_release, cyc);
            end
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: press %b release %b cycle %0d, none expected", bus.key_press, bus.key_release, cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (cyc != e.at) begin
                    bad++;
                    $display("FAIL strobe_cycle: got cycle %0d want %0d", cyc, e.at);
                end
                check("strobe_press", bus.key_press, e.press);
                check("strobe_release", bus.key_release, e.rel);
                check("strobe_level", bus.key_out, e.out);
            end
        end
    end

    initial begin
        // Reset with all pins low: outputs must still read released.
        bus.key_in = 4'b0000;
        reset_n    = 1'b0;
        step(3);
        check("reset_out", bus.key_out, 4'b1111);
        check("reset_press", bus.key_press, 4'b0000);
        check("reset_release", bus.key_release, 4'b0000);
        bus.key_in = 4'b1111;
        reset_n    = 1'b1;
        step(50);
        check("idle_out", bus.key_out, 4'b1111);

        // Clean press and release of key 0.
        bus.key_in = 4'b1110;
        expect_strobe(4'b0001, 4'b0000, 4'b1110);
        step(LAT + 5);
        check("press0_level", bus.key_out, 4'b1110);
        bus.key_in = 4'b1111;
        expect_strobe(4'b0000, 4'b0001, 4'b1111);
        step(LAT + 5);

        // Bouncing key 1, 3-cycle phases, then held low.
        for (int k = 0; k < 4; k++) begin
            bus.key_in[1] = (k % 2 == 1);
            step(3);
        end
        check("bounce_no_accept", bus.key_out, 4'b1111);
        bus.key_in[1] = 1'b0;
        expect_strobe(4'b0010, 4'b0000, 4'b1101);
        step(LAT + 5);
        bus.key_in = 4'b1111;
        expect_strobe(4'b0000, 4'b0010, 4'b1111);
        step(LAT + 5);

        // Key 2: 7-cycle glitch rejected, 8-cycle low accepted then released.
        bus.key_in = 4'b1011;
        step(7);
        bus.key_in = 4'b1111;
        step(LAT + 5);
        check("glitch7_level", bus.key_out, 4'b1111);
        bus.key_in = 4'b1011;
        expect_strobe(4'b0100, 4'b0000, 4'b1011);
        step(8);
        bus.key_in = 4'b1111;
        expect_strobe(4'b0000, 4'b0100, 4'b1111);
        step(LAT + 5);

        // All keys together.
        bus.key_in = 4'b0000;
        expect_strobe(4'b1111, 4'b0000, 4'b0000);
        step(LAT + 5);
        check("all_low", bus.key_out, 4'b0000);
        bus.key_in = 4'b1111;
        expect_strobe(4'b0000, 4'b1111, 4'b1111);
        step(LAT + 5);

        // Reset in the middle of key 3 qualification.
        bus.key_in = 4'b0111;
        step(7);
        reset_n = 1'b0;
        #1;
        check("midreset_out", bus.key_out, 4'b1111);
        check("midreset_press", bus.key_press, 4'b0000);
        step(2);
        reset_n = 1'b1;
        expect_strobe(4'b1000, 4'b0000, 4'b0111);
        step(LAT + 5);
        check("after_reset_level", bus.key_out, 4'b0111);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_strobes: %0d expected strobes never seen", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
